cola_buyer: RTL and testbench
=============================

COLA_BUYER -- requirements
Module: cola_buyer

Interface
REQ-001 Parameter PRICE, default 3, number of coin pulses per purchase (range 1..15).
REQ-002 Parameter GAP, default 2, idle cycles between consecutive coin pulses (range 0..15).
REQ-003 Parameter TIMEOUT, default 8, WAIT cycles allowed without a cola before error (range 1..255).
REQ-004 sys_clk  input  1  clock; all logic on rising edge.
REQ-005 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 buy_req  input  1  purchase request, sampled only in IDLE.
REQ-007 pi_cola  input  1  one-cycle cola-delivered pulse from the vending machine.
REQ-008 po_money  output  1  one-cycle coin pulse to the vending machine money input, registered.
REQ-009 buy_busy  output  1  high while a purchase is in progress (any state except IDLE).
REQ-010 buy_done  output  1  one-cycle pulse when a purchase completes with a cola.
REQ-011 buy_err  output  1  one-cycle pulse when a purchase times out.
REQ-012 cola_cnt  output  8  count of completed purchases, saturating at 255.

Function
REQ-013 FSM SHALL have states IDLE, COIN, GAP, WAIT, one-hot encoded.
REQ-014 IDLE: buy_req=1 at an edge -> COIN; coin counter cleared; otherwise stay.
REQ-015 COIN: one cycle only; po_money=1 for exactly this cycle; coin counter +1.
REQ-016 COIN exit: after coin number PRICE -> WAIT; else GAP=0 -> COIN (back-to-back), else -> GAP.
REQ-017 GAP: po_money=0 for exactly GAP cycles, then -> COIN.
REQ-018 WAIT: pi_cola=1 at an edge -> IDLE; buy_done=1 and cola_cnt+1 in the next cycle.
REQ-019 Latency: buy_req sampled at edge k -> po_money high in cycle k+1; coin n high in cycle k+1+(n-1)*(GAP+1).
REQ-020 cola_cnt SHALL saturate: at 255 a further completion leaves it at 255 and still pulses buy_done.
REQ-021 buy_req while buy_busy=1 SHALL be ignored, not queued.
REQ-022 pi_cola in any state other than WAIT SHALL be ignored (no buy_done, no count change).
REQ-023 buy_done and buy_err SHALL never be high in the same cycle.
REQ-024 buy_busy SHALL be low in the cycle buy_done or buy_err pulses, so a new buy_req can be sampled that cycle.

Reset
REQ-025 On sys_rst_n=0: state=IDLE, po_money=0, buy_busy=0, buy_done=0, buy_err=0, cola_cnt=0, all counters 0.
REQ-026 Reset mid-purchase SHALL abort immediately with no buy_done or buy_err pulse; a partially paid purchase is not resumed.

Configuration
REQ-027 Macro COLA_BUYER_TIMEOUT_EN defined: WAIT counts cycles; after TIMEOUT cycles in WAIT without pi_cola -> IDLE, buy_err=1 next cycle, cola_cnt unchanged.
REQ-028 With COLA_BUYER_TIMEOUT_EN defined, pi_cola on the final allowed WAIT cycle SHALL win over timeout (buy_done, not buy_err).
REQ-029 COLA_BUYER_TIMEOUT_EN undefined: WAIT waits indefinitely, buy_err tied to 0, no timeout counter synthesized.

Structure
REQ-030 Package cola_pkg SHALL hold the one-hot state constants and the PRICE/GAP/TIMEOUT defaults.
REQ-031 Sub-module cola_cycle_timer (loadable 8-bit down-counter with zero flag) SHALL time both GAP and TIMEOUT.

Verification (PRICE=3, GAP=2, TIMEOUT=8; buy_req pulse in cycle 0)
REQ-032 Bench covers the nominal case: pi_cola in cycle 8 -> po_money high in cycles 1, 4, 7 only; buy_busy high in cycles 1..8; buy_done and cola_cnt=1 in cycle 9.
REQ-033 Bench covers timeout: macro on, no pi_cola -> WAIT cycles 8..15, buy_err in cycle 16, cola_cnt stays 0; macro off -> buy_busy stays high indefinitely.
REQ-034 Bench covers ignored inputs: buy_req held high cycles 0..20 with pi_cola in cycle 8 -> second purchase starts, first coin in cycle 10; pi_cola injected in cycle 3 -> no effect.
REQ-035 Bench covers mid-purchase reset: sys_rst_n low in cycle 5 -> outputs zero immediately; no pulses; next buy_req gives the full 3 coins.
REQ-036 Bench covers edge parameters: GAP=0 gives coins in cycles 1, 2, 3; 256 completions give cola_cnt=255 with 256 buy_done pulses.
REQ-037 Bench covers the timeout/cola race: macro on, pi_cola in cycle 15 -> buy_done in cycle 16, no buy_err.

Source files
------------

// File: rtl/cola_pkg.sv
// Shared definitions for the cola buyer: one-hot FSM states, parameter defaults
// and a saturating counter helper.
package cola_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_COIN = 4'b0010,
        ST_GAP  = 4'b0100,
        ST_WAIT = 4'b1000
    } state_e;

    localparam int DEF_PRICE   = 3;
    localparam int DEF_GAP     = 2;
    localparam int DEF_TIMEOUT = 8;

    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        return (val == 8'hFF) ? val : val + 8'd1;
    endfunction

endpackage

// File: rtl/cola_cycle_timer.sv
// Loadable 8-bit down-counter with zero flag; times the coin gap and the
// WAIT timeout of the cola buyer.
module cola_cycle_timer (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       dec_i,
    output logic       zero_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Load has priority over decrement; the counter parks at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == 8'd0);

endmodule

// File: rtl/cola_buyer.sv
// Cola buyer: pays PRICE coin pulses spaced GAP idle cycles apart, then waits
// for the cola. Optional WAIT timeout is enabled by macro COLA_BUYER_TIMEOUT_EN.
module cola_buyer
    import cola_pkg::*;
#(
    parameter int PRICE   = DEF_PRICE,
    parameter int GAP     = DEF_GAP,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       buy_req,
    input  logic       pi_cola,
    output logic       po_money,
    output logic       buy_busy,
    output logic       buy_done,
    output logic       buy_err,
    output logic [7:0] cola_cnt
);

    localparam logic [3:0] PRICE_LAST = 4'(PRICE - 1);
    localparam logic [7:0] GAP_LOAD   = 8'((GAP > 0) ? (GAP - 1) : 0);

    state_e     state_q;
    state_e     state_d;
    logic [3:0] coin_q;
    logic [3:0] coin_d;
    logic       tmr_load_s;
    logic [7:0] tmr_load_val_s;
    logic       tmr_dec_s;
    logic       tmr_zero_s;
    logic       done_s;
    logic       po_money_q;
    logic       buy_busy_q;
    logic       buy_done_q;
    logic [7:0] cola_cnt_q;
`ifdef COLA_BUYER_TIMEOUT_EN
    localparam logic [7:0] TO_LOAD = 8'(TIMEOUT - 1);
    logic       err_s;
    logic       buy_err_q;
`endif

    cola_cycle_timer u_timer (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .load_i     (tmr_load_s),
        .load_val_i (tmr_load_val_s),
        .dec_i      (tmr_dec_s),
        .zero_o     (tmr_zero_s)
    );

    // Next-state, coin counting and timer control.
    always_comb begin
        state_d        = state_q;
        coin_d         = coin_q;
        tmr_load_s     = 1'b0;
        tmr_load_val_s = GAP_LOAD;
        tmr_dec_s      = 1'b0;
        done_s         = 1'b0;
`ifdef COLA_BUYER_TIMEOUT_EN
        err_s          = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (buy_req) begin
                    state_d = ST_COIN;
                    coin_d  = 4'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COIN: begin
                coin_d = coin_q + 4'd1;
                if (coin_q == PRICE_LAST) begin
                    state_d = ST_WAIT;
`ifdef COLA_BUYER_TIMEOUT_EN
                    tmr_load_s     = 1'b1;
                    tmr_load_val_s = TO_LOAD;
`endif
                end else if (GAP == 0) begin
                    state_d = ST_COIN;
                end else begin
                    state_d    = ST_GAP;
                    tmr_load_s = 1'b1;
                end
            end
            ST_GAP: begin
                if (tmr_zero_s) begin
                    state_d = ST_COIN;
                end else begin
                    tmr_dec_s = 1'b1;
                end
            end
            ST_WAIT: begin
                // A cola on the last allowed cycle beats the timeout.
                if (pi_cola) begin
                    state_d = ST_IDLE;
                    done_s  = 1'b1;
                end
`ifdef COLA_BUYER_TIMEOUT_EN
                else if (tmr_zero_s) begin
                    state_d = ST_IDLE;
                    err_s   = 1'b1;
                end else begin
                    tmr_dec_s = 1'b1;
                end
`else
                else begin
                    state_d = ST_WAIT;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, coin counter and registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            coin_q     <= 4'd0;
            po_money_q <= 1'b0;
            buy_busy_q <= 1'b0;
            buy_done_q <= 1'b0;
            cola_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            coin_q     <= coin_d;
            po_money_q <= (state_d == ST_COIN);
            buy_busy_q <= (state_d != ST_IDLE);
            buy_done_q <= done_s;
            cola_cnt_q <= done_s ? sat_inc8(cola_cnt_q) : cola_cnt_q;
        end
    end

`ifdef COLA_BUYER_TIMEOUT_EN
    // Timeout error pulse register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            buy_err_q <= 1'b0;
        end else begin
            buy_err_q <= err_s;
        end
    end
    assign buy_err = buy_err_q;
`else
    assign buy_err = 1'b0;
`endif

    assign po_money = po_money_q;
    assign buy_busy = buy_busy_q;
    assign buy_done = buy_done_q;
    assign cola_cnt = cola_cnt_q;

endmodule

// File: tb/tb_cola_buyer.sv
// Self-checking bench for cola_buyer: a default instance (GAP=2) and a GAP=0
// instance share stimulus and are compared against a timing-formula model.
module tb_cola_buyer;

    localparam int MAXC    = 4096;
    localparam int PRICE   = 3;
    localparam int TIMEOUT = 8;
`ifdef COLA_BUYER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       buy_req = 1'b0;
    logic       pi_cola = 1'b0;
    logic [1:0] po_money_s;
    logic [1:0] buy_busy_s;
    logic [1:0] buy_done_s;
    logic [1:0] buy_err_s;
    logic [7:0] cola_cnt0_s;
    logic [7:0] cola_cnt1_s;

    bit          req_a  [MAXC];
    bit          cola_a [MAXC];
    bit          m_a    [MAXC];
    bit          b_a    [MAXC];
    bit          d_a    [MAXC];
    bit          e_a    [MAXC];
    logic [11:0] obs_vec [2][MAXC];
    logic [11:0] exp_vec [2][MAXC];
    int checks = 0;
    int errors = 0;

    cola_buyer #(.PRICE(PRICE), .GAP(2), .TIMEOUT(TIMEOUT)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .buy_req(buy_req), .pi_cola(pi_cola),
        .po_money(po_money_s[0]), .buy_busy(buy_busy_s[0]), .buy_done(buy_done_s[0]),
        .buy_err(buy_err_s[0]), .cola_cnt(cola_cnt0_s)
    );

    cola_buyer #(.PRICE(PRICE), .GAP(0), .TIMEOUT(TIMEOUT)) dut_g0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .buy_req(buy_req), .pi_cola(pi_cola),
        .po_money(po_money_s[1]), .buy_busy(buy_busy_s[1]), .buy_done(buy_done_s[1]),
        .buy_err(buy_err_s[1]), .cola_cnt(cola_cnt1_s)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_stim();
        for (int i = 0; i < MAXC; i++) begin
            req_a[i]  = 1'b0;
            cola_a[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        buy_req   = 1'b0;
        pi_cola   = 1'b0;
        sys_rst_n = 1'b0;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
    endtask

    // Drive one cycle per stimulus entry and record both instances at the negedge.
    task automatic run(input int len, input int rst_at);
        for (int t = 0; t < len; t++) begin
            buy_req = req_a[t];
            pi_cola = cola_a[t];
            if (t == rst_at) sys_rst_n = 1'b0;
            @(negedge sys_clk);
            obs_vec[0][t] = {po_money_s[0], buy_busy_s[0], buy_done_s[0], buy_err_s[0], cola_cnt0_s};
            obs_vec[1][t] = {po_money_s[1], buy_busy_s[1], buy_done_s[1], buy_err_s[1], cola_cnt1_s};
            if (t == rst_at) begin
                #1;
                sys_rst_n = 1'b1;
            end
            @(posedge sys_clk);
            #1;
        end
        buy_req = 1'b0;
        pi_cola = 1'b0;
    endtask

    // Transaction-level model: a purchase accepted at cycle s pays coin n in
    // cycle s+1+(n-1)*(gap+1), waits from the cycle after the last coin, and
    // reports in the cycle after the cola (or after TIMEOUT waiting cycles).
    task automatic model(input int inst, input int gap, input int lo, input int hi);
        int t, s, w, c, ncola;
        bit fin, to;
        for (int i = lo; i < hi; i++) begin
            m_a[i] = 1'b0; b_a[i] = 1'b0; d_a[i] = 1'b0; e_a[i] = 1'b0;
        end
        t = lo;
        while (t < hi) begin
            if (!req_a[t]) begin
                t++;
                continue;
            end
            s = t;
            for (int n = 1; n <= PRICE; n++) begin
                if (s + 1 + (n - 1) * (gap + 1) < hi) m_a[s + 1 + (n - 1) * (gap + 1)] = 1'b1;
            end
            w   = s + 1 + (PRICE - 1) * (gap + 1) + 1;
            c   = w;
            fin = 1'b0;
            to  = 1'b0;
            while (!fin && c < hi) begin
                if (cola_a[c]) fin = 1'b1;
                else if (TO_EN && c == w + TIMEOUT - 1) begin fin = 1'b1; to = 1'b1; end
                else c++;
            end
            for (int b = s + 1; b <= c && b < hi; b++) b_a[b] = 1'b1;
            if (fin && c + 1 < hi) begin
                if (to) e_a[c + 1] = 1'b1;
                else    d_a[c + 1] = 1'b1;
            end
            t = fin ? c + 1 : hi;
        end
        ncola = 0;
        for (int i = lo; i < hi; i++) begin
            if (d_a[i]) ncola = (ncola < 255) ? ncola + 1 : 255;
            exp_vec[inst][i] = {m_a[i], b_a[i], d_a[i], e_a[i], 8'(ncola)};
        end
    endtask

    task automatic model_both(input int lo, input int hi);
        model(0, 2, lo, hi);
        model(1, 0, lo, hi);
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        buy_req   = 1'b1;
        pi_cola   = 1'b1;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        for (int k = 0; k < 2; k++) begin
            logic [11:0] got;
            got = (k == 0) ? {po_money_s[0], buy_busy_s[0], buy_done_s[0], buy_err_s[0], cola_cnt0_s}
                           : {po_money_s[1], buy_busy_s[1], buy_done_s[1], buy_err_s[1], cola_cnt1_s};
            checks++;
            if (got !== 12'h000) begin
                errors++;
                $display("FAIL reset inst%0d: got %h expected %h", k, got, 12'h000);
            end
        end
        do_reset();
    endtask

    task automatic test_nominal();
        bit [5:0] g0_pat;
        clear_stim();
        req_a[0] = 1'b1;
        cola_a[8] = 1'b1;
        do_reset();
        run(14, -1);
        model_both(0, 14);
        for (int i = 0; i < 14; i++) begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_vec[k][i] !== exp_vec[k][i]) begin
                    errors++;
                    $display("FAIL nominal inst%0d cycle %0d: got %h expected %h", k, i, obs_vec[k][i], exp_vec[k][i]);
                end
            end
        end
        checks++;
        if (obs_vec[0][9] !== 12'h201) begin
            errors++;
            $display("FAIL nominal_done9: got %h expected %h", obs_vec[0][9], 12'h201);
        end
        g0_pat = 6'b001110;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs_vec[1][i][11] !== g0_pat[i]) begin
                errors++;
                $display("FAIL gap0_coin cycle %0d: got %b expected %b", i, obs_vec[1][i][11], g0_pat[i]);
            end
        end
    endtask

    task automatic test_timeout();
        clear_stim();
        req_a[0] = 1'b1;
        do_reset();
        run(24, -1);
        model_both(0, 24);
        for (int i = 0; i < 24; i++) begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_vec[k][i] !== exp_vec[k][i]) begin
                    errors++;
                    $display("FAIL timeout inst%0d cycle %0d: got %h expected %h", k, i, obs_vec[k][i], exp_vec[k][i]);
                end
            end
        end
`ifdef COLA_BUYER_TIMEOUT_EN
        checks++;
        if (obs_vec[0][16] !== 12'h100) begin
            errors++;
            $display("FAIL timeout_err16: got %h expected %h", obs_vec[0][16], 12'h100);
        end
`else
        checks++;
        if (obs_vec[0][23] !== 12'h400) begin
            errors++;
            $display("FAIL timeout_busy_forever: got %h expected %h", obs_vec[0][23], 12'h400);
        end
`endif
    endtask

    task automatic test_race();
        clear_stim();
        req_a[0] = 1'b1;
        cola_a[15] = 1'b1;
        do_reset();
        run(20, -1);
        model_both(0, 20);
        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_vec[k][i] !== exp_vec[k][i]) begin
                    errors++;
                    $display("FAIL race inst%0d cycle %0d: got %h expected %h", k, i, obs_vec[k][i], exp_vec[k][i]);
                end
            end
        end
        checks++;
        if (obs_vec[0][16] !== 12'h201) begin
            errors++;
            $display("FAIL race_done16: got %h expected %h", obs_vec[0][16], 12'h201);
        end
    endtask

    task automatic test_ignored();
        clear_stim();
        for (int i = 0; i <= 20; i++) req_a[i] = 1'b1;
        cola_a[3] = 1'b1;
        cola_a[8] = 1'b1;
        do_reset();
        run(30, -1);
        model_both(0, 30);
        for (int i = 0; i < 30; i++) begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_vec[k][i] !== exp_vec[k][i]) begin
                    errors++;
                    $display("FAIL ignored inst%0d cycle %0d: got %h expected %h", k, i, obs_vec[k][i], exp_vec[k][i]);
                end
            end
        end
        checks++;
        if (obs_vec[0][10][11] !== 1'b1 || obs_vec[0][9][10] !== 1'b0) begin
            errors++;
            $display("FAIL ignored_restart: got coin10=%b busy9=%b expected coin10=1 busy9=0",
                     obs_vec[0][10][11], obs_vec[0][9][10]);
        end
    endtask

    task automatic test_reset_mid();
        int coins;
        clear_stim();
        req_a[0] = 1'b1;
        req_a[7] = 1'b1;
        cola_a[15] = 1'b1;
        do_reset();
        run(22, 5);
        model_both(0, 5);
        model_both(5, 22);
        for (int i = 0; i < 22; i++) begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_vec[k][i] !== exp_vec[k][i]) begin
                    errors++;
                    $display("FAIL reset_mid inst%0d cycle %0d: got %h expected %h", k, i, obs_vec[k][i], exp_vec[k][i]);
                end
            end
        end
        checks++;
        if (obs_vec[0][5] !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid_zero: got %h expected %h", obs_vec[0][5], 12'h000);
        end
        coins = 0;
        for (int i = 7; i < 16; i++) coins += int'(obs_vec[0][i][11]);
        checks++;
        if (coins != PRICE) begin
            errors++;
            $display("FAIL reset_mid_coins: got %0d expected %0d", coins, PRICE);
        end
    endtask

    task automatic test_saturation();
        int len, dones;
        clear_stim();
        len = 2310;
        for (int i = 0; i <= 255 * 9; i++) req_a[i] = 1'b1;
        for (int i = 0; i < len; i++) cola_a[i] = 1'b1;
        do_reset();
        run(len, -1);
        model_both(0, len);
        for (int i = 0; i < len; i++) begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_vec[k][i] !== exp_vec[k][i]) begin
                    errors++;
                    $display("FAIL saturation inst%0d cycle %0d: got %h expected %h", k, i, obs_vec[k][i], exp_vec[k][i]);
                end
            end
        end
        dones = 0;
        for (int i = 0; i < len; i++) dones += int'(obs_vec[0][i][9]);
        checks++;
        if (dones != 256 || obs_vec[0][len - 1][7:0] !== 8'd255) begin
            errors++;
            $display("FAIL saturation_total: got dones=%0d cnt=%0d expected dones=256 cnt=255",
                     dones, obs_vec[0][len - 1][7:0]);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            clear_stim();
            for (int i = 0; i < 400; i++) begin
                req_a[i]  = ($urandom_range(0, 2) == 0);
                cola_a[i] = ($urandom_range(0, 3) == 0);
            end
            do_reset();
            run(400, -1);
            model_both(0, 400);
            for (int i = 0; i < 400; i++) begin
                for (int k = 0; k < 2; k++) begin
                    checks++;
                    if (obs_vec[k][i] !== exp_vec[k][i]) begin
                        errors++;
                        $display("FAIL random it%0d inst%0d cycle %0d: got %h expected %h",
                                 it, k, i, obs_vec[k][i], exp_vec[k][i]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_timeout();
        test_race();
        test_ignored();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
